// File: rtl/support_io_pkg.sv
// support_io_pkg: shared constants for the support_io mailbox slot.
// Holds the register map, STATUS/IRQEN bit positions, the idle-read byte
// and the record type used to hold a captured CPU access.
package support_io_pkg;

    // Register map within the slot
    localparam logic [3:0] ADDR_DATA   = 4'd0;
    localparam logic [3:0] ADDR_STATUS = 4'd1;
    localparam logic [3:0] ADDR_RXLVL  = 4'd2;
    localparam logic [3:0] ADDR_TXLVL  = 4'd3;
    localparam logic [3:0] ADDR_IRQEN  = 4'd4;

    // STATUS bit positions
    localparam int ST_TX_NE   = 0;
    localparam int ST_RX_FULL = 1;
    localparam int ST_OVF     = 2;
    localparam int ST_UNF     = 3;

    // IRQEN bit positions
    localparam int IE_TX_NE = 0;
    localparam int IE_OVF   = 1;
    localparam int IE_UNF   = 2;

    // Byte returned for unmapped addresses and an empty DATA read
    localparam logic [7:0] IDLE_READ = 8'hFF;

    // One CPU access as captured while its strobe is low
    typedef struct packed {
        logic [3:0] addr;
        logic [7:0] data;
    } access_t;

endpackage

// File: rtl/support_io_fifo.sv
// support_io_fifo: synchronous byte FIFO with first-word-fall-through head.
// Pointers carry one extra wrap bit so full and empty are told apart without
// a separate counter; the storage array itself is never reset.
module support_io_fifo #(
    parameter int DEPTH  = 8,
    parameter int DATA_W = 8
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic                     push,
    input  logic [DATA_W-1:0]        push_data,
    input  logic                     pop,
    output logic [DATA_W-1:0]        head,
    output logic                     empty,
    output logic                     full,
    output logic [$clog2(DEPTH):0]   level
);
    localparam int AW = $clog2(DEPTH);

    logic [DATA_W-1:0] mem [DEPTH];
    logic [AW:0]       wptr;
    logic [AW:0]       rptr;
    logic              push_ok;
    logic              pop_ok;

    // A push into a full FIFO is dropped even if a pop happens in the same cycle
    assign push_ok = push && !full;
    assign pop_ok  = pop && !empty;

    assign empty = (wptr == rptr);
    assign full  = (wptr[AW] != rptr[AW]) && (wptr[AW-1:0] == rptr[AW-1:0]);
    assign level = wptr - rptr;
    assign head  = mem[rptr[AW-1:0]];

    // Advance read/write pointers; both wrap naturally modulo 2*DEPTH
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            wptr <= '0;
            rptr <= '0;
        end else begin
            if (push_ok) wptr <= wptr + 1'b1;
            if (pop_ok)  rptr <= rptr + 1'b1;
        end
    end

    // Write storage; contents are only meaningful between rptr and wptr
    always_ff @(posedge clk) begin
        if (push_ok) mem[wptr[AW-1:0]] <= push_data;
    end

endmodule

// File: rtl/support_io_mailbox.sv
// support_io_mailbox: byte mailbox between an asynchronous CPU slot and a
// local ready/valid interface. The CPU strobes are synchronized; an access
// commits on the synchronized rising edge of its strobe, acting one edge
// later using the address/data captured while the strobe was low.
// Optional feature: define SUPPORT_IO_MAILBOX_IRQ_EN to add the IRQEN
// register at address 4 and drive irq_o; otherwise irq_o is tied low.
module support_io_mailbox
    import support_io_pkg::*;
#(
    parameter int DEPTH = 8
) (
    input  logic       clk_i,
    input  logic       rst_i,
    input  logic [3:0] A_i,
    input  logic       nrd_i,
    input  logic       nwr_i,
    input  logic [7:0] D_i,
    output logic [7:0] D_o,
    output logic [7:0] rx_data_o,
    output logic       rx_valid_o,
    input  logic       rx_ready_i,
    input  logic [7:0] tx_data_i,
    input  logic       tx_valid_i,
    output logic       tx_ready_o,
    output logic       irq_o
);
    localparam int LW = $clog2(DEPTH) + 1;

    // Strobe vectors: index 0 is the write strobe, index 1 the read strobe
    logic [1:0] sync_p0;
    logic [1:0] sync_p1;
    logic [1:0] sync_p2;
    logic [1:0] warm;
    logic [1:0] hi_seen;
    logic [1:0] armed;
    logic [1:0] commit_p1;
    access_t    acc_p0;

    logic          wr_commit;
    logic          rd_commit;
    logic          rx_push;
    logic          rx_pop;
    logic [7:0]    rx_head;
    logic          rx_empty;
    logic          rx_full;
    logic [LW-1:0] rx_level;
    logic          tx_push;
    logic          tx_pop_req;
    logic [7:0]    tx_head;
    logic          tx_empty;
    logic          tx_full;
    logic [LW-1:0] tx_level;
    logic          ovf;
    logic          unf;
    logic          ovf_set;
    logic          ovf_clr;
    logic          unf_set;
    logic          unf_clr;
    logic [7:0]    status;
    logic [7:0]    rd_data;

    // Occupancy as a register byte; only DEPTH=256 full needs the clamp
    function automatic logic [7:0] lvl_byte(input logic [LW-1:0] lvl);
        if (32'(lvl) > 32'd255) return 8'hFF;
        return 8'(lvl);
    endfunction

    // Two-flop synchronizers plus edge history; warm marks when the second
    // stage stops showing its reset value and starts tracking the pins
    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            sync_p0   <= 2'b11;
            sync_p1   <= 2'b11;
            sync_p2   <= 2'b11;
            warm      <= 2'b00;
            hi_seen   <= 2'b00;
            armed     <= 2'b00;
            commit_p1 <= 2'b00;
        end else begin
            sync_p0   <= {nrd_i, nwr_i};
            sync_p1   <= sync_p0;
            sync_p2   <= sync_p1;
            warm      <= {warm[0], 1'b1};
            // A strobe arms only on a real high->low seen after reset, so a
            // pin held low through reset release never produces a commit
            hi_seen   <= hi_seen | ({2{warm[1]}} & sync_p1);
            armed     <= armed | (hi_seen & ~sync_p1);
            commit_p1 <= armed & sync_p1 & ~sync_p2;
        end
    end

    // Track address/data while either synchronized strobe is low
    always_ff @(posedge clk_i) begin
        if (!(&sync_p1)) acc_p0 <= '{addr: A_i, data: D_i};
    end

    // ---- commit stage: act on the captured access ----
    assign wr_commit  = commit_p1[0];
    assign rd_commit  = commit_p1[1];

    assign rx_push    = wr_commit && (acc_p0.addr == ADDR_DATA);
    assign rx_pop     = rx_valid_o && rx_ready_i;
    assign ovf_set    = rx_push && rx_full;
    assign ovf_clr    = wr_commit && (acc_p0.addr == ADDR_STATUS) && acc_p0.data[ST_OVF];

    assign tx_push    = tx_valid_i && tx_ready_o;
    assign tx_pop_req = rd_commit && (acc_p0.addr == ADDR_DATA);
    assign unf_set    = tx_pop_req && tx_empty;
    assign unf_clr    = wr_commit && (acc_p0.addr == ADDR_STATUS) && acc_p0.data[ST_UNF];

    // CPU-to-local direction
    support_io_fifo #(.DEPTH(DEPTH), .DATA_W(8)) u_rx_fifo (
        .clk       (clk_i),
        .rst       (rst_i),
        .push      (rx_push),
        .push_data (acc_p0.data),
        .pop       (rx_pop),
        .head      (rx_head),
        .empty     (rx_empty),
        .full      (rx_full),
        .level     (rx_level)
    );

    // Local-to-CPU direction; the FIFO ignores a pop while empty
    support_io_fifo #(.DEPTH(DEPTH), .DATA_W(8)) u_tx_fifo (
        .clk       (clk_i),
        .rst       (rst_i),
        .push      (tx_push),
        .push_data (tx_data_i),
        .pop       (tx_pop_req),
        .head      (tx_head),
        .empty     (tx_empty),
        .full      (tx_full),
        .level     (tx_level)
    );

    // Sticky error flags; a set in the same cycle as a clear wins
    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            ovf <= 1'b0;
            unf <= 1'b0;
        end else begin
            ovf <= (ovf && !ovf_clr) || ovf_set;
            unf <= (unf && !unf_clr) || unf_set;
        end
    end

`ifdef SUPPORT_IO_MAILBOX_IRQ_EN
    logic [2:0] irqen;
    logic [2:0] irq_src;
    logic       irq;

    // IRQEN register written by a committed CPU write to its address
    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            irqen <= 3'b000;
        end else if (wr_commit && (acc_p0.addr == ADDR_IRQEN)) begin
            irqen <= acc_p0.data[2:0];
        end
    end

    // Interrupt sources in IRQEN bit order
    always_comb begin
        irq_src           = 3'b000;
        irq_src[IE_TX_NE] = !tx_empty;
        irq_src[IE_OVF]   = ovf;
        irq_src[IE_UNF]   = unf;
    end

    // Registered OR of the enabled sources
    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) irq <= 1'b0;
        else       irq <= |(irqen & irq_src);
    end

    assign irq_o = irq;
`else
    assign irq_o = 1'b0;
`endif

    // STATUS byte assembled from live FIFO state and sticky flags
    always_comb begin
        status             = 8'h00;
        status[ST_TX_NE]   = !tx_empty;
        status[ST_RX_FULL] = rx_full;
        status[ST_OVF]     = ovf;
        status[ST_UNF]     = unf;
    end

    // Combinational read mux on the live address pins; idle byte in reset
    always_comb begin
        rd_data = IDLE_READ;
        if (!rst_i) begin
            case (A_i)
                ADDR_DATA:   rd_data = tx_empty ? IDLE_READ : tx_head;
                ADDR_STATUS: rd_data = status;
                ADDR_RXLVL:  rd_data = lvl_byte(rx_level);
                ADDR_TXLVL:  rd_data = lvl_byte(tx_level);
`ifdef SUPPORT_IO_MAILBOX_IRQ_EN
                ADDR_IRQEN:  rd_data = {5'b00000, irqen};
`endif
                default:     rd_data = IDLE_READ;
            endcase
        end
    end

    assign D_o        = rd_data;
    assign rx_valid_o = !rx_empty;
    assign rx_data_o  = rx_empty ? 8'h00 : rx_head;
    assign tx_ready_o = !tx_full;

endmodule

// File: tb/tb_support_io_mailbox.sv
// tb_support_io_mailbox: self-checking bench for support_io_mailbox.
// Directed table of CPU/local operations, hand-written multi-cycle
// sequences, then randomized traffic against a queue-based model.
module tb_support_io_mailbox;
    localparam int DEPTH = 8;

    logic       clk_i = 1'b0;
    logic       rst_i;
    logic [3:0] A_i;
    logic       nrd_i;
    logic       nwr_i;
    logic [7:0] D_i;
    logic [7:0] D_o;
    logic [7:0] rx_data_o;
    logic       rx_valid_o;
    logic       rx_ready_i;
    logic [7:0] tx_data_i;
    logic       tx_valid_i;
    logic       tx_ready_o;
    logic       irq_o;

    int n_checks = 0;
    int n_errs   = 0;

    support_io_mailbox #(.DEPTH(DEPTH)) dut (
        .clk_i      (clk_i),
        .rst_i      (rst_i),
        .A_i        (A_i),
        .nrd_i      (nrd_i),
        .nwr_i      (nwr_i),
        .D_i        (D_i),
        .D_o        (D_o),
        .rx_data_o  (rx_data_o),
        .rx_valid_o (rx_valid_o),
        .rx_ready_i (rx_ready_i),
        .tx_data_i  (tx_data_i),
        .tx_valid_i (tx_valid_i),
        .tx_ready_o (tx_ready_o),
        .irq_o      (irq_o)
    );

    always #5 clk_i = ~clk_i;

    typedef enum {OP_WR, OP_RD, OP_LPUSH, OP_LPOP} op_e;
    typedef struct {
        op_e        op;
        logic [3:0] a;
        logic [7:0] d;
        logic [7:0] exp;
    } vec_t;

    vec_t vecs[$];

    // Reference model state
    logic [7:0] rxq[$];
    logic [7:0] txq[$];
    logic       m_ovf;
    logic       m_unf;
    logic [2:0] m_irqen;

    function automatic void add(input op_e op, input logic [3:0] a,
                                input logic [7:0] d, input logic [7:0] e);
        vecs.push_back('{op: op, a: a, d: d, exp: e});
    endfunction

    task automatic tick();
        @(posedge clk_i);
        #1;
    endtask

    task automatic check(input string name, input logic [7:0] act, input logic [7:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_errs++;
            $display("FAIL %s: got %02h, expected %02h", name, act, exp);
        end
    endtask

    task automatic cpu_write(input logic [3:0] a, input logic [7:0] d);
        A_i = a;
        D_i = d;
        nwr_i = 1'b0;
        repeat (3) tick();
        nwr_i = 1'b1;
        repeat (6) tick();
    endtask

    task automatic cpu_read(input logic [3:0] a, output logic [7:0] d);
        A_i = a;
        nrd_i = 1'b0;
        repeat (3) tick();
        d = D_o;
        nrd_i = 1'b1;
        repeat (6) tick();
    endtask

    task automatic local_push(input logic [7:0] d);
        tx_data_i  = d;
        tx_valid_i = 1'b1;
        tick();
        tx_valid_i = 1'b0;
        tick();
    endtask

    task automatic local_pop(output logic [7:0] d, output logic v);
        d = rx_data_o;
        v = rx_valid_o;
        rx_ready_i = 1'b1;
        tick();
        rx_ready_i = 1'b0;
        tick();
    endtask

    task automatic do_reset();
        rst_i = 1'b1;
        repeat (2) tick();
        rst_i = 1'b0;
        repeat (3) tick();
    endtask

    function automatic logic [7:0] model_read(input logic [3:0] a);
        case (a)
            4'd0: return (txq.size() == 0) ? 8'hFF : txq[0];
            4'd1: return {4'b0000, m_unf, m_ovf, rxq.size() == DEPTH, txq.size() != 0};
            4'd2: return 8'(rxq.size());
            4'd3: return 8'(txq.size());
`ifdef SUPPORT_IO_MAILBOX_IRQ_EN
            4'd4: return {5'b00000, m_irqen};
`endif
            default: return 8'hFF;
        endcase
    endfunction

    function automatic logic model_irq();
`ifdef SUPPORT_IO_MAILBOX_IRQ_EN
        return |(m_irqen & {m_unf, m_ovf, txq.size() != 0});
`else
        return 1'b0;
`endif
    endfunction

    function automatic void model_write(input logic [3:0] a, input logic [7:0] d);
        case (a)
            4'd0: begin
                if (rxq.size() < DEPTH) rxq.push_back(d);
                else m_ovf = 1'b1;
            end
            4'd1: begin
                if (d[2]) m_ovf = 1'b0;
                if (d[3]) m_unf = 1'b0;
            end
`ifdef SUPPORT_IO_MAILBOX_IRQ_EN
            4'd4: m_irqen = d[2:0];
`endif
            default: ;
        endcase
    endfunction

    initial begin
        #2_000_000;
        $display("FAIL watchdog: time limit reached, got no finish, expected finish");
        $fatal(1, "watchdog");
    end

    initial begin
        logic [7:0] r;
        logic       v;
        int         sel;
        logic [3:0] ra;
        logic [7:0] rd;

        rst_i = 1'b1;
        A_i = 4'd1;
        nrd_i = 1'b1;
        nwr_i = 1'b1;
        D_i = 8'h00;
        rx_ready_i = 1'b0;
        tx_data_i = 8'h00;
        tx_valid_i = 1'b0;
        repeat (2) tick();

        // Output values while reset is held
        check("reset rx_valid", {7'd0, rx_valid_o}, 8'h00);
        check("reset tx_ready", {7'd0, tx_ready_o}, 8'h01);
        check("reset irq", {7'd0, irq_o}, 8'h00);
        check("reset rx_data", rx_data_o, 8'h00);
        check("reset D_o", D_o, 8'hFF);
        rst_i = 1'b0;
        repeat (3) tick();
        cpu_read(4'd1, r);
        check("post-reset STATUS", r, 8'h00);

        // Write latency: rx_valid rises on the 4th edge after nwr_i rises
        A_i = 4'd0;
        D_i = 8'h5A;
        nwr_i = 1'b0;
        repeat (3) tick();
        nwr_i = 1'b1;
        repeat (3) tick();
        check("latency edge3 rx_valid", {7'd0, rx_valid_o}, 8'h00);
        tick();
        check("latency edge4 rx_valid", {7'd0, rx_valid_o}, 8'h01);
        check("latency edge4 rx_data", rx_data_o, 8'h5A);
        repeat (2) tick();
        cpu_read(4'd2, r);
        check("latency RXLVL", r, 8'h01);
        local_pop(r, v);
        check("latency pop data", r, 8'h5A);

        // Directed table
        for (int i = 1; i <= 9; i++) add(OP_WR, 4'd0, 8'(i), 8'h00);
        add(OP_RD, 4'd2, 8'h00, 8'h08);
        add(OP_RD, 4'd1, 8'h00, 8'h06);
        add(OP_WR, 4'd1, 8'h04, 8'h00);
        add(OP_RD, 4'd1, 8'h00, 8'h02);
        for (int i = 1; i <= 8; i++) add(OP_LPOP, 4'd0, 8'h00, 8'(i));
        add(OP_RD, 4'd2, 8'h00, 8'h00);
        add(OP_RD, 4'd1, 8'h00, 8'h00);
        add(OP_LPUSH, 4'd0, 8'h11, 8'h00);
        add(OP_LPUSH, 4'd0, 8'h22, 8'h00);
        add(OP_RD, 4'd3, 8'h00, 8'h02);
        add(OP_RD, 4'd1, 8'h00, 8'h01);
        add(OP_RD, 4'd0, 8'h00, 8'h11);
        add(OP_RD, 4'd0, 8'h00, 8'h22);
        add(OP_RD, 4'd0, 8'h00, 8'hFF);
        add(OP_RD, 4'd1, 8'h00, 8'h08);
        add(OP_WR, 4'd1, 8'h08, 8'h00);
        add(OP_RD, 4'd1, 8'h00, 8'h00);
        add(OP_WR, 4'd5, 8'hAB, 8'h00);
        add(OP_RD, 4'd2, 8'h00, 8'h00);
        add(OP_RD, 4'd7, 8'h00, 8'hFF);
        add(OP_RD, 4'd15, 8'h00, 8'hFF);
`ifdef SUPPORT_IO_MAILBOX_IRQ_EN
        add(OP_RD, 4'd4, 8'h00, 8'h00);
`else
        add(OP_WR, 4'd4, 8'h07, 8'h00);
        add(OP_RD, 4'd4, 8'h00, 8'hFF);
`endif
        foreach (vecs[i]) begin
            case (vecs[i].op)
                OP_WR:    cpu_write(vecs[i].a, vecs[i].d);
                OP_LPUSH: local_push(vecs[i].d);
                OP_RD: begin
                    cpu_read(vecs[i].a, r);
                    check($sformatf("vec%0d read a=%0d", i, vecs[i].a), r, vecs[i].exp);
                end
                OP_LPOP: begin
                    local_pop(r, v);
                    check($sformatf("vec%0d pop valid", i), {7'd0, v}, 8'h01);
                    check($sformatf("vec%0d pop data", i), r, vecs[i].exp);
                end
                default: ;
            endcase
        end

        // Local pop in the same cycle as a CPU push commit at RXLVL=3
        cpu_write(4'd0, 8'hA1);
        cpu_write(4'd0, 8'hA2);
        cpu_write(4'd0, 8'hA3);
        A_i = 4'd0;
        D_i = 8'hA4;
        nwr_i = 1'b0;
        repeat (3) tick();
        nwr_i = 1'b1;
        repeat (3) tick();
        check("concurrent head before", rx_data_o, 8'hA1);
        rx_ready_i = 1'b1;
        tick();
        rx_ready_i = 1'b0;
        repeat (5) tick();
        cpu_read(4'd2, r);
        check("concurrent RXLVL", r, 8'h03);
        local_pop(r, v);
        check("concurrent order 1", r, 8'hA2);
        local_pop(r, v);
        check("concurrent order 2", r, 8'hA3);
        local_pop(r, v);
        check("concurrent order 3", r, 8'hA4);
        check("concurrent drained", {7'd0, rx_valid_o}, 8'h00);

        // Interrupt behaviour
`ifdef SUPPORT_IO_MAILBOX_IRQ_EN
        cpu_write(4'd4, 8'h01);
        local_push(8'h99);
        tick();
        check("irq after push", {7'd0, irq_o}, 8'h01);
        cpu_read(4'd0, r);
        check("irq read data", r, 8'h99);
        check("irq after read", {7'd0, irq_o}, 8'h00);
        cpu_write(4'd4, 8'h00);
`else
        local_push(8'h99);
        tick();
        check("irq tied low", {7'd0, irq_o}, 8'h00);
        cpu_read(4'd0, r);
        check("irq read data", r, 8'h99);
`endif

        // Write strobe held low through reset release
        rst_i = 1'b1;
        A_i = 4'd0;
        D_i = 8'h77;
        nwr_i = 1'b0;
        repeat (2) tick();
        rst_i = 1'b0;
        repeat (4) tick();
        nwr_i = 1'b1;
        repeat (6) tick();
        cpu_read(4'd2, r);
        check("stuck-low RXLVL", r, 8'h00);
        check("stuck-low rx_valid", {7'd0, rx_valid_o}, 8'h00);
        cpu_write(4'd0, 8'h33);
        cpu_read(4'd2, r);
        check("after stuck-low RXLVL", r, 8'h01);
        check("after stuck-low rx_data", rx_data_o, 8'h33);

        // Reset asserted mid-access abandons the pending push
        local_push(8'h55);
        A_i = 4'd0;
        D_i = 8'h66;
        nwr_i = 1'b0;
        repeat (3) tick();
        nwr_i = 1'b1;
        repeat (2) tick();
        rst_i = 1'b1;
        A_i = 4'd1;
        #1;
        check("mid reset rx_valid", {7'd0, rx_valid_o}, 8'h00);
        check("mid reset tx_ready", {7'd0, tx_ready_o}, 8'h01);
        check("mid reset rx_data", rx_data_o, 8'h00);
        check("mid reset D_o", D_o, 8'hFF);
        check("mid reset irq", {7'd0, irq_o}, 8'h00);
        tick();
        rst_i = 1'b0;
        repeat (6) tick();
        check("abandon rx_valid", {7'd0, rx_valid_o}, 8'h00);
        cpu_read(4'd2, r);
        check("abandon RXLVL", r, 8'h00);
        cpu_read(4'd3, r);
        check("abandon TXLVL", r, 8'h00);
        cpu_read(4'd1, r);
        check("abandon STATUS", r, 8'h00);

        // Randomized traffic against the queue model
        do_reset();
        rxq.delete();
        txq.delete();
        m_ovf = 1'b0;
        m_unf = 1'b0;
        m_irqen = 3'b000;
        for (int k = 0; k < 400; k++) begin
            sel = $urandom_range(0, 9);
            ra = ($urandom_range(0, 3) == 0) ? 4'($urandom_range(0, 15))
                                             : 4'($urandom_range(0, 1));
            rd = 8'($urandom);
            if (sel <= 3) begin
                cpu_write(ra, rd);
                model_write(ra, rd);
            end else if (sel <= 6) begin
                ra = ($urandom_range(0, 1) == 0) ? 4'd0 : 4'($urandom_range(0, 5));
                cpu_read(ra, r);
                check($sformatf("rnd%0d read a=%0d", k, ra), r, model_read(ra));
                if (ra == 4'd0) begin
                    if (txq.size() != 0) void'(txq.pop_front());
                    else m_unf = 1'b1;
                end
            end else if (sel <= 8) begin
                check($sformatf("rnd%0d tx_ready", k), {7'd0, tx_ready_o},
                      {7'd0, txq.size() < DEPTH});
                local_push(rd);
                if (txq.size() < DEPTH) txq.push_back(rd);
            end else begin
                local_pop(r, v);
                check($sformatf("rnd%0d pop valid", k), {7'd0, v}, {7'd0, rxq.size() != 0});
                if (rxq.size() != 0) begin
                    check($sformatf("rnd%0d pop data", k), r, rxq[0]);
                    void'(rxq.pop_front());
                end
            end
            check($sformatf("rnd%0d rx_valid", k), {7'd0, rx_valid_o}, {7'd0, rxq.size() != 0});
            check($sformatf("rnd%0d rx_data", k), rx_data_o,
                  (rxq.size() != 0) ? rxq[0] : 8'h00);
            check($sformatf("rnd%0d irq", k), {7'd0, irq_o}, {7'd0, model_irq()});
        end
        cpu_read(4'd1, r);
        check("rnd final STATUS", r, model_read(4'd1));

        $display("Result: errors=%0d of %0d checks", n_errs, n_checks);
        $finish;
    end

endmodule
